// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
//   state_t : FSM encoding {IDLE, RUN, DONE}
//   ndig()  : digits per operation (WIDTH / DIGIT)
//   cnt_w() : digit counter width, at least one bit
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // $clog2(1) is 0; keep a one-bit counter for the single-digit case
    function automatic int unsigned cnt_w(input int unsigned width, input int unsigned digit);
        return (ndig(width, digit) > 1) ? $clog2(ndig(width, digit)) : 1;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple slice built from full-adder cells.
// Ports:
//   x, y     : DIGIT-bit operand digits
//   cin      : carry into the digit LSB
//   s        : DIGIT-bit sum digit
//   cout     : carry out of the digit MSB
//   c_msb_in : carry into the digit MSB (for signed overflow)
module adder_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    // Ripple through the digit, remembering the carry entering the top bit
    always_comb begin
        c        = cin;
        s        = '0;
        c_msb_in = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) begin
                c_msb_in = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock through one reused ripple slice, with a one-cycle done strobe.
// Optional feature macro: ADDER_OVF_EN (enables the signed overflow flag;
// without it ovf is tied low).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted in IDLE or DONE
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : operands (sampled with start)
//   busy       : digits being processed
//   done       : one-cycle result-valid strobe
//   sum        : result, cleared on an accepted start
//   cout       : carry out of the MSB (for sub: 1 = no borrow)
//   ovf        : two's-complement overflow
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG  = ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_t           state;
    state_t           state_nx;
    logic             accept_c;
    logic             busy_nx;
    logic             done_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_c_msb;

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .x        (a_q[cnt*DIGIT +: DIGIT]),
        .y        (b_q[cnt*DIGIT +: DIGIT]),
        .cin      (carry),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_c_msb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; start is only honoured in IDLE or DONE (back-to-back)
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == DONE);
    end

    // Datapath: capture on accept, one digit per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            if (accept_c) begin
                a_q   <= a;
                b_q   <= b ^ {WIDTH{sub}};
                carry <= sub;
                cnt   <= '0;
                sum   <= '0;
            end else if (state == RUN) begin
                sum[cnt*DIGIT +: DIGIT] <= dig_s;
                carry                   <= dig_cout;
                cnt                     <= cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    cout <= dig_cout;
                end
            end
        end
    end

`ifdef ADDER_OVF_EN
    // Overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (state == RUN && cnt == LAST && !accept_c) begin
            ovf <= dig_c_msb ^ dig_cout;
        end
    end
`else
    logic unused_c_msb;
    assign unused_c_msb = dig_c_msb;
    assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=8, DIGIT=2).
// Expected results are queued when a start is driven and popped at done.
module tb_digit_serial_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIGIT = 2;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   tests;
    int   fails;
    exp_t sb[$];

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        exp_t             e;
        logic [WIDTH-1:0] yx;
        logic [WIDTH:0]   full;
        yx     = y ^ {WIDTH{s}};
        full   = {1'b0, x} + {1'b0, yx} + {{WIDTH{1'b0}}, s};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
`ifdef ADDER_OVF_EN
        e.ovf  = (x[WIDTH-1] == yx[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    // Drive one start pulse sampled at the next rising edge; optionally queue its result
    task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic s, input bit push);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        if (push) sb.push_back(model(x, y, s));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count negedges after the start edge until done (bounded)
    task automatic wait_done(output int lat, output bit overlap, output bit busy1);
        lat     = 0;
        overlap = 1'b0;
        busy1   = 1'b0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy1 = busy;
            if (busy && done) overlap = 1'b1;
            if (done || lat >= 20) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all zero",
                     busy, done, sum, cout, ovf);
        end
    endtask

    // One operation with full latency and result checks
    task automatic run_op(input string name, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic s);
        int   lat;
        bit   ov;
        bit   b1;
        exp_t e;
        drive_start(x, y, s, 1'b1);
        wait_done(lat, ov, b1);
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL %s_latency: got %0d, required 5", name, lat);
        end
        tests++;
        if (b1 !== 1'b1 || ov !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy: busy_first=%b overlap=%b, required 1/0", name, b1, ov);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '{default: 'x};
        tests++;
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            fails++;
            $display("FAIL %s_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_add_ovf;
        run_op("add_ovf", 8'h5A, 8'h3C, 1'b0);
`ifdef ADDER_OVF_EN
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL add_ovf_flag: got %b, required 1", ovf);
        end
`endif
        tests++;
        if (sum !== 8'h96) begin
            fails++;
            $display("FAIL add_ovf_const: got %h, required 96", sum);
        end
    endtask

    task automatic test_add_wrap;
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0);
        tests++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            fails++;
            $display("FAIL add_wrap_const: sum=%h cout=%b, required 00/1", sum, cout);
        end
    endtask

    task automatic test_sub;
        run_op("sub_borrow", 8'h10, 8'h20, 1'b1);
        tests++;
        if (sum !== 8'hF0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL sub_borrow_const: sum=%h cout=%b, required F0/0", sum, cout);
        end
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1);
        tests++;
        if (sum !== 8'h7F || cout !== 1'b1) begin
            fails++;
            $display("FAIL sub_ovf_const: sum=%h cout=%b, required 7F/1", sum, cout);
        end
    endtask

    task automatic test_start_while_busy;
        int   ndone;
        logic [WIDTH-1:0] got;
        exp_t e;
        ndone = 0;
        got   = 'x;
        drive_start(8'h01, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h22;
        b     = 8'h22;
        sub   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                got = sum;
            end
        end
        tests++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL busy_start_count: got %0d dones, required 1", ndone);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '{default: 'x};
        tests++;
        if (got !== e.sum) begin
            fails++;
            $display("FAIL busy_start_sum: got %h, required %h", got, e.sum);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        drive_start(8'h37, 8'h15, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || sum !== '0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_state: busy=%b sum=%h done=%b, required 0/00/0", busy, sum, done);
        end
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL reset_mid_done: got %0d dones, required 0", ndone);
        end
        run_op("after_reset", 8'h37, 8'h15, 1'b0);
    endtask

    task automatic test_back_to_back;
        int   lat;
        bit   ov;
        bit   b1;
        exp_t e;
        drive_start(8'h33, 8'h11, 1'b0, 1'b1);
        wait_done(lat, ov, b1);
        tests++;
        if (lat !== 5 || ov !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: latency=%0d overlap=%b, required 5/0", lat, ov);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '{default: 'x};
        tests++;
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            fails++;
            $display("FAIL b2b_first_result: sum=%h cout=%b ovf=%b, required %h/%b/%b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        // Still in the DONE cycle: request the next operation
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h01;
        sub   = 1'b0;
        sb.push_back(model(8'h0F, 8'h01, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, ov, b1);
        tests++;
        if (lat !== 5 || ov !== 1'b0 || b1 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_timing: latency=%0d overlap=%b busy_first=%b, required 5/0/1",
                     lat, ov, b1);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '{default: 'x};
        tests++;
        if (sum !== e.sum || sum !== 8'h10 || cout !== e.cout) begin
            fails++;
            $display("FAIL b2b_second_result: sum=%h cout=%b, required %h/%b", sum, cout, e.sum, e.cout);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            run_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add_ovf();
        test_add_wrap();
        test_sub();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
